// File: rtl/esfa_trial_scheduler.sv
// Batch sequencer for ESFATop trials: re-arms the core, launches each trial and accumulates results.
// Optional per-trial watchdog is compiled in with ESFA_TRIAL_WATCHDOG_EN.
module esfa_trial_scheduler #(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned REARM_CYCLES = 2
`ifdef ESFA_TRIAL_WATCHDOG_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic             masterClock,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] trialCount,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] passCount,
   output logic [CNT_W-1:0] failCount,
   output logic [CNT_W-1:0] timeoutCount,
   output logic [CNT_W-1:0] firstFailTrial,
   output logic [7:0]       firstFailInstr,
   output logic             coreRearm,
   output logic             doRun,
   input  logic             isRunning,
   input  logic             didRun,
   input  logic             wasSuccessful,
   input  logic [7:0]       instructionOfError
);

   localparam int unsigned RW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;
   localparam logic [RW-1:0] REARM_LAST = RW'(REARM_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, REARM, LAUNCH, RUN, RECORD, FINISH} state_t;

   state_t           state, nextState;
   logic [CNT_W-1:0] countLatched;
   logic [CNT_W-1:0] trialIdx;
   logic [CNT_W-1:0] trialIdxInc;
   logic [RW-1:0]    rearmCnt;
   logic             startBatch;
   logic             startZero;
   logic             wdExpired;
   logic             timeoutHit;
   logic             timedOut;

   assign trialIdxInc = trialIdx + CNT_W'(1);
   assign startBatch  = (state == IDLE) && start && (trialCount != '0);
   assign startZero   = (state == IDLE) && start && (trialCount == '0);

`ifdef ESFA_TRIAL_WATCHDOG_EN
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wdCnt;

   // Counter is zero whenever outside LAUNCH/RUN, so it is clear on every LAUNCH entry.
   always_ff @(posedge masterClock) begin
      if (reset || !(state == LAUNCH || state == RUN)) wdCnt <= '0;
      else                                             wdCnt <= wdCnt + 1'b1;
   end

   assign wdExpired = (state == LAUNCH || state == RUN) && (wdCnt == WW'(TIMEOUT_CYCLES - 1));
`else
   assign wdExpired    = 1'b0;
   assign timeoutCount = '0;
`endif

   always_ff @(posedge masterClock) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState  = state;
      timeoutHit = 1'b0;
      case (state)
         IDLE:   if (startBatch) nextState = REARM;
         REARM:  if (abort) nextState = FINISH;
                 else if (rearmCnt == REARM_LAST) nextState = LAUNCH;
         LAUNCH: if (abort) nextState = FINISH;
                 else if (isRunning || didRun) nextState = RUN;
                 else if (wdExpired) begin
                    nextState  = RECORD;
                    timeoutHit = 1'b1;
                 end
         RUN:    if (abort) nextState = FINISH;
                 else if (didRun && !isRunning) nextState = RECORD;
                 else if (wdExpired) begin
                    nextState  = RECORD;
                    timeoutHit = 1'b1;
                 end
         RECORD: if (abort || trialIdxInc == countLatched) nextState = FINISH;
                 else nextState = REARM;
         FINISH: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs are registered from nextState so they line up with the state they describe.
   always_ff @(posedge masterClock) begin
      if (reset) begin
         busy           <= 1'b0;
         done           <= 1'b0;
         aborted        <= 1'b0;
         coreRearm      <= 1'b0;
         doRun          <= 1'b0;
         timedOut       <= 1'b0;
         rearmCnt       <= '0;
         countLatched   <= '0;
         trialIdx       <= '0;
         passCount      <= '0;
         failCount      <= '0;
         firstFailTrial <= '1;
         firstFailInstr <= 8'hFF;
`ifdef ESFA_TRIAL_WATCHDOG_EN
         timeoutCount   <= '0;
`endif
      end else begin
         busy      <= (nextState != IDLE);
         done      <= (nextState == FINISH) || startZero;
         coreRearm <= (nextState == REARM);
         doRun     <= (nextState == LAUNCH);
         timedOut  <= timeoutHit;
         rearmCnt  <= (state == REARM) ? rearmCnt + 1'b1 : '0;

         if (state == IDLE && start) begin
            countLatched   <= trialCount;
            trialIdx       <= '0;
            passCount      <= '0;
            failCount      <= '0;
            firstFailTrial <= '1;
            firstFailInstr <= 8'hFF;
            aborted        <= 1'b0;
`ifdef ESFA_TRIAL_WATCHDOG_EN
            timeoutCount   <= '0;
`endif
         end

         if (abort && (state == REARM || state == LAUNCH || state == RUN || state == RECORD))
            aborted <= 1'b1;

         if (state == RECORD) begin
            trialIdx <= trialIdxInc;
            if (wasSuccessful && !timedOut) begin
               passCount <= passCount + CNT_W'(1);
            end else begin
               failCount <= failCount + CNT_W'(1);
               if (failCount == '0) begin
                  firstFailTrial <= trialIdx;
                  firstFailInstr <= timedOut ? 8'hFF : instructionOfError;
               end
`ifdef ESFA_TRIAL_WATCHDOG_EN
               if (timedOut) timeoutCount <= timeoutCount + CNT_W'(1);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_esfa_trial_scheduler.sv
// Self-checking bench for esfa_trial_scheduler with a behavioural ESFATop core model and a result scoreboard.
module tb_esfa_trial_scheduler;

   localparam int RUN_LEN = 10;

   logic        masterClock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] trialCount = '0;
   logic        abort = 1'b0;
   logic        busy, done, aborted, coreRearm, doRun;
   logic [15:0] passCount, failCount, timeoutCount, firstFailTrial;
   logic [7:0]  firstFailInstr;
   logic        isRunning, didRun, wasSuccessful;
   logic [7:0]  instructionOfError;

   typedef struct {
      int          pass;
      int          fail;
      int          tmo;
      logic [15:0] fft;
      logic [7:0]  ffi;
      logic        ab;
   } exp_t;

   exp_t sb[$];
   int   nChecks = 0;
   int   nFails  = 0;

   bit       failMask[16];
   bit       hang[16];
   bit [7:0] errInstr[16];

   always #5 masterClock = ~masterClock;

   esfa_trial_scheduler #(
      .CNT_W(16),
      .REARM_CYCLES(2)
`ifdef ESFA_TRIAL_WATCHDOG_EN
      , .TIMEOUT_CYCLES(50)
`endif
   ) dut (
      .masterClock(masterClock), .reset(reset), .start(start), .trialCount(trialCount),
      .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .passCount(passCount), .failCount(failCount), .timeoutCount(timeoutCount),
      .firstFailTrial(firstFailTrial), .firstFailInstr(firstFailInstr),
      .coreRearm(coreRearm), .doRun(doRun), .isRunning(isRunning), .didRun(didRun),
      .wasSuccessful(wasSuccessful), .instructionOfError(instructionOfError)
   );

   // Core model: each launch runs RUN_LEN cycles; per-launch outcome comes from the tables above.
   int launchIdx, curTrial, runCnt;
   always @(posedge masterClock) begin
      if (reset) begin
         launchIdx <= 0; curTrial <= 0; runCnt <= 0;
         isRunning <= 1'b0; didRun <= 1'b0; wasSuccessful <= 1'b0; instructionOfError <= 8'h00;
      end else if (coreRearm) begin
         isRunning <= 1'b0; didRun <= 1'b0; wasSuccessful <= 1'b0;
      end else if (doRun && !isRunning && !didRun) begin
         isRunning <= 1'b1; runCnt <= RUN_LEN - 1; curTrial <= launchIdx; launchIdx <= launchIdx + 1;
      end else if (isRunning && !hang[curTrial]) begin
         if (runCnt == 0) begin
            isRunning <= 1'b0; didRun <= 1'b1;
            wasSuccessful <= !failMask[curTrial];
            instructionOfError <= errInstr[curTrial];
         end else begin
            runCnt <= runCnt - 1;
         end
      end
   end

   function automatic exp_t model(input int cnt);
      exp_t e;
      e.pass = 0; e.fail = 0; e.tmo = 0; e.fft = '1; e.ffi = 8'hFF; e.ab = 1'b0;
      for (int i = 0; i < cnt; i++) begin
         if (hang[i] || failMask[i]) begin
            if (e.fail == 0) begin
               e.fft = 16'(i);
               e.ffi = hang[i] ? 8'hFF : errInstr[i];
            end
            e.fail++;
            if (hang[i]) e.tmo++;
         end else begin
            e.pass++;
         end
      end
      return e;
   endfunction

   task automatic clear_tables();
      for (int i = 0; i < 16; i++) begin
         failMask[i] = 1'b0; hang[i] = 1'b0; errInstr[i] = 8'h00;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; trialCount = '0;
      repeat (2) @(posedge masterClock);
      #1 reset = 1'b0;
   endtask

   task automatic launch(input logic [15:0] cnt);
      @(posedge masterClock);
      #1 start = 1'b1; trialCount = cnt;
      @(posedge masterClock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge masterClock);
         if (done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic wait_trial_running(input int idx, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge masterClock);
         if (launchIdx == idx + 1 && isRunning === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      clear_tables();
      do_reset();
      @(negedge masterClock);
      nChecks++;
      if ({busy, done, aborted, coreRearm, doRun} !== 5'b0) begin
         nFails++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, aborted, coreRearm, doRun});
      end
      nChecks++;
      if ({passCount, failCount, timeoutCount} !== 48'h0) begin
         nFails++; $display("FAIL reset_counters: got %h/%h/%h expected 0/0/0", passCount, failCount, timeoutCount);
      end
      nChecks++;
      if (firstFailTrial !== 16'hFFFF || firstFailInstr !== 8'hFF) begin
         nFails++; $display("FAIL reset_firstfail: got %h/%h expected ffff/ff", firstFailTrial, firstFailInstr);
      end
   endtask

   task automatic test_all_pass();
      exp_t e;
      bit   seen;
      clear_tables();
      do_reset();
      sb.push_back(model(5));
      launch(16'd5);
      @(negedge masterClock);
      nChecks++;
      if ({busy, coreRearm, doRun} !== 3'b110) begin
         nFails++; $display("FAIL timing_edge1: got busy,rearm,run=%b expected 110", {busy, coreRearm, doRun});
      end
      @(negedge masterClock);
      nChecks++;
      if ({busy, coreRearm, doRun} !== 3'b110) begin
         nFails++; $display("FAIL timing_edge2: got busy,rearm,run=%b expected 110", {busy, coreRearm, doRun});
      end
      @(negedge masterClock);
      nChecks++;
      if ({busy, coreRearm, doRun} !== 3'b101) begin
         nFails++; $display("FAIL timing_edge3: got busy,rearm,run=%b expected 101", {busy, coreRearm, doRun});
      end
      launch(16'd2);
      wait_done(600, seen);
      nChecks++;
      if (!seen) begin
         nFails++; $display("FAIL all_pass_done: got no done expected done within 600 cycles");
      end
      e = sb.pop_front();
      nChecks++;
      if (passCount !== 16'(e.pass) || failCount !== 16'(e.fail) || timeoutCount !== 16'(e.tmo)) begin
         nFails++; $display("FAIL all_pass_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                            passCount, failCount, timeoutCount, e.pass, e.fail, e.tmo);
      end
      nChecks++;
      if (firstFailTrial !== e.fft || busy !== 1'b1) begin
         nFails++; $display("FAIL all_pass_fft_busy: got %h/%b expected %h/1", firstFailTrial, busy, e.fft);
      end
      @(negedge masterClock);
      nChecks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         nFails++; $display("FAIL all_pass_after: got done=%b busy=%b expected 0/0", done, busy);
      end
   endtask

   task automatic test_fail_pattern();
      exp_t e;
      bit   seen;
      clear_tables();
      do_reset();
      failMask[2] = 1'b1; errInstr[2] = 8'h37;
      failMask[4] = 1'b1; errInstr[4] = 8'h11;
      sb.push_back(model(6));
      launch(16'd6);
      wait_done(600, seen);
      nChecks++;
      if (!seen) begin
         nFails++; $display("FAIL fail_pattern_done: got no done expected done within 600 cycles");
      end
      e = sb.pop_front();
      nChecks++;
      if (passCount !== 16'(e.pass) || failCount !== 16'(e.fail)) begin
         nFails++; $display("FAIL fail_pattern_counts: got %0d/%0d expected %0d/%0d", passCount, failCount, e.pass, e.fail);
      end
      nChecks++;
      if (firstFailTrial !== e.fft || firstFailInstr !== e.ffi) begin
         nFails++; $display("FAIL fail_pattern_first: got %h/%h expected %h/%h", firstFailTrial, firstFailInstr, e.fft, e.ffi);
      end
   endtask

   task automatic test_zero_count();
      exp_t e;
      bit   busySeen;
      clear_tables();
      sb.push_back(model(0));
      launch(16'd0);
      @(negedge masterClock);
      busySeen = busy;
      nChecks++;
      if (done !== 1'b1) begin
         nFails++; $display("FAIL zero_done: got %b expected 1", done);
      end
      e = sb.pop_front();
      nChecks++;
      if (passCount !== 16'(e.pass) || failCount !== 16'(e.fail) || firstFailTrial !== e.fft || firstFailInstr !== e.ffi) begin
         nFails++; $display("FAIL zero_clear: got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                            passCount, failCount, firstFailTrial, firstFailInstr, e.pass, e.fail, e.fft, e.ffi);
      end
      @(negedge masterClock);
      busySeen |= busy;
      nChecks++;
      if (done !== 1'b0 || busySeen !== 1'b0) begin
         nFails++; $display("FAIL zero_pulse: got done=%b busyEver=%b expected 0/0", done, busySeen);
      end
   endtask

   task automatic test_abort();
      exp_t e;
      bit   seen;
      clear_tables();
      do_reset();
      e.pass = 3; e.fail = 0; e.tmo = 0; e.fft = '1; e.ffi = 8'hFF; e.ab = 1'b1;
      sb.push_back(e);
      launch(16'd8);
      wait_trial_running(3, seen);
      @(negedge masterClock);
      abort = 1'b1;
      @(posedge masterClock);
      #1 abort = 1'b0;
      @(negedge masterClock);
      nChecks++;
      if (!seen || doRun !== 1'b0 || coreRearm !== 1'b0 || done !== 1'b1) begin
         nFails++; $display("FAIL abort_now: got reached=%b doRun=%b rearm=%b done=%b expected 1/0/0/1", seen, doRun, coreRearm, done);
      end
      e = sb.pop_front();
      nChecks++;
      if (aborted !== e.ab || (passCount + failCount) !== 16'(e.pass + e.fail)) begin
         nFails++; $display("FAIL abort_state: got aborted=%b trials=%0d expected %b/%0d", aborted, passCount + failCount, e.ab, e.pass + e.fail);
      end
      sb.push_back(model(1));
      launch(16'd1);
      @(negedge masterClock);
      nChecks++;
      if (aborted !== 1'b0) begin
         nFails++; $display("FAIL abort_cleared: got %b expected 0", aborted);
      end
      wait_done(200, seen);
      e = sb.pop_front();
      nChecks++;
      if (!seen || passCount !== 16'(e.pass) || aborted !== 1'b0) begin
         nFails++; $display("FAIL abort_rerun: got done=%b pass=%0d aborted=%b expected 1/%0d/0", seen, passCount, aborted, e.pass);
      end
   endtask

   task automatic test_reset_midrun();
      bit seen;
      clear_tables();
      do_reset();
      launch(16'd4);
      wait_trial_running(2, seen);
      repeat (2) @(negedge masterClock);
      nChecks++;
      if (!seen || passCount !== 16'd2 || doRun !== 1'b0 || busy !== 1'b1) begin
         nFails++; $display("FAIL midrun_before: got reached=%b pass=%0d doRun=%b busy=%b expected 1/2/0/1", seen, passCount, doRun, busy);
      end
      reset = 1'b1;
      @(negedge masterClock);
      reset = 1'b0;
      nChecks++;
      if ({busy, done, aborted, coreRearm, doRun} !== 5'b0 || passCount !== 16'd0 || firstFailTrial !== 16'hFFFF) begin
         nFails++; $display("FAIL midrun_reset: got ctrl=%b pass=%0d fft=%h expected 00000/0/ffff",
                            {busy, done, aborted, coreRearm, doRun}, passCount, firstFailTrial);
      end
      wait_done(40, seen);
      nChecks++;
      if (seen || busy !== 1'b0) begin
         nFails++; $display("FAIL midrun_quiet: got done=%b busy=%b expected 0/0", seen, busy);
      end
   endtask

`ifdef ESFA_TRIAL_WATCHDOG_EN
   task automatic test_watchdog();
      exp_t e;
      bit   seen;
      clear_tables();
      do_reset();
      hang[0] = 1'b1;
      sb.push_back(model(3));
      launch(16'd3);
      wait_done(600, seen);
      e = sb.pop_front();
      nChecks++;
      if (!seen || timeoutCount !== 16'(e.tmo) || failCount !== 16'(e.fail) || passCount !== 16'(e.pass)) begin
         nFails++; $display("FAIL watchdog_counts: got done=%b tmo=%0d fail=%0d pass=%0d expected 1/%0d/%0d/%0d",
                            seen, timeoutCount, failCount, passCount, e.tmo, e.fail, e.pass);
      end
      nChecks++;
      if (firstFailTrial !== e.fft || firstFailInstr !== e.ffi) begin
         nFails++; $display("FAIL watchdog_first: got %h/%h expected %h/%h", firstFailTrial, firstFailInstr, e.fft, e.ffi);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_all_pass();
      test_fail_pattern();
      test_zero_count();
      test_abort();
      test_reset_midrun();
`ifdef ESFA_TRIAL_WATCHDOG_EN
      test_watchdog();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
